// File: rtl/ap_pkg.sv
// ap_pkg: shared constants and types for the audio-processing datapath.
package ap_pkg;
  localparam int DATA_WIDTH = 12;
  localparam int NUM_FEAT   = 26;
  localparam int SEG_LEN    = 16;
  localparam int SEG_SHIFT  = $clog2(SEG_LEN);
  localparam int ADC_OFFSET = 2048;
  localparam int FRAME_LEN  = NUM_FEAT * SEG_LEN;
  localparam int ACC_W      = 16;
  localparam int SEG_W      = $clog2(NUM_FEAT);
  typedef logic signed [15:0] feat_t;
  typedef feat_t feat_vec_t [NUM_FEAT];
endpackage

// File: rtl/ap_preemph_abs.sv
// ap_preemph_abs: offset removal, first-order pre-emphasis and magnitude,
// two register stages with a matching valid pipeline.
module ap_preemph_abs
  import ap_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] adc_data_i,
  output logic [DATA_WIDTH-1:0] abs_o,
  output logic                  valid_o
);
  localparam int W  = DATA_WIDTH + 1;
  localparam int PW = W + 5;
  localparam logic signed [W-1:0] OFS = W'(ADC_OFFSET);
  logic signed [W-1:0] x_q, x_d, xp_q;
  logic signed [PW-1:0] prod;
  logic signed [W:0] y;
  logic [DATA_WIDTH-1:0] abs_q, abs_d;
  logic valid1_q, valid2_q;
  always_comb begin
    x_d   = $signed({1'b0, adc_data_i}) - OFS;
    prod  = PW'(xp_q) * PW'(31);
    y     = (W+1)'(x_q) - (W+1)'(prod >>> 5);
    abs_d = y[W] ? DATA_WIDTH'(-y) : DATA_WIDTH'(y);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      x_q      <= '0;
      xp_q     <= '0;
      abs_q    <= '0;
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      valid1_q <= 1'b1;
      valid2_q <= valid1_q;
      if (valid1_q) begin
        abs_q <= abs_d;
        xp_q  <= x_q;
      end
    end
  assign abs_o   = abs_q;
  assign valid_o = valid2_q;
endmodule

// File: rtl/top_ap.sv
// top_ap: per-segment mean absolute amplitude of the pre-emphasised stream,
// collected into a shadow buffer and published once per frame.
module top_ap
  import ap_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] adc_data,
  output feat_vec_t             output_vector
);
  logic [DATA_WIDTH-1:0] a;
  logic v2, seg_end, done_q, done_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [SEG_SHIFT-1:0] samp_q, samp_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  feat_vec_t shadow_q, out_q;
  ap_preemph_abs u_pre (
    .clk        (clk),
    .rst        (rst),
    .adc_data_i (adc_data),
    .abs_o      (a),
    .valid_o    (v2)
  );
  always_comb begin
    sum     = acc_q + ACC_W'(a);
    seg_end = v2 && samp_q == SEG_SHIFT'(SEG_LEN - 1);
    samp_d  = v2 ? samp_q + 1'b1 : samp_q;
    acc_d   = seg_end ? '0 : v2 ? sum : acc_q;
    done_d  = seg_end && seg_q == SEG_W'(NUM_FEAT - 1);
    seg_d   = done_d ? '0 : seg_end ? seg_q + 1'b1 : seg_q;
  end
  // The last segment lands in the shadow on the same edge done_q rises,
  // so the copy one edge later publishes a complete frame atomically.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc_q    <= '0;
      samp_q   <= '0;
      seg_q    <= '0;
      done_q   <= 1'b0;
      shadow_q <= '{default: '0};
      out_q    <= '{default: '0};
    end else begin
      acc_q  <= acc_d;
      samp_q <= samp_d;
      seg_q  <= seg_d;
      done_q <= done_d;
      if (seg_end) shadow_q[seg_q] <= feat_t'(sum >> SEG_SHIFT);
      if (done_q) out_q <= shadow_q;
    end
  assign output_vector = out_q;
endmodule

// File: tb/tb_top_ap.sv
// tb_top_ap: directed checks of top_ap feature values, update timing and reset.
module tb_top_ap;
  import ap_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [DATA_WIDTH-1:0] adc_data = 12'h800;
  feat_vec_t ov;
  int n_chk = 0;
  int n_fail = 0;

  top_ap dut (.clk(clk), .rst(rst), .adc_data(adc_data), .output_vector(ov));

  always #5 clk = ~clk;

  task automatic feed(input logic [DATA_WIDTH-1:0] v);
    adc_data = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NUM_FEAT; k++) begin
      n_chk++;
      if (ov[k] !== 16'sd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %0d expected 0", k, ov[k]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_zero();
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      feed(12'h800);
      for (int k = 0; k < NUM_FEAT; k++) begin
        n_chk++;
        if (ov[k] !== 16'sd0) begin
          n_fail++;
          $display("FAIL zero[%0d] n=%0d: got %0d expected 0", k, n, ov[k]);
        end
      end
    end
  endtask

  task automatic test_const();
    do_reset();
    repeat (418) feed(12'hA00);
    for (int k = 0; k < NUM_FEAT; k++) begin
      n_chk++;
      if (ov[k] !== 16'sd0) begin
        n_fail++;
        $display("FAIL pre_update[%0d]: got %0d expected 0", k, ov[k]);
      end
    end
    feed(12'hA00);
    for (int k = 0; k < NUM_FEAT; k++) begin
      n_chk++;
      if (ov[k] !== ((k == 0) ? 16'sd47 : 16'sd16)) begin
        n_fail++;
        $display("FAIL const[%0d]: got %0d expected %0d", k, ov[k], (k == 0) ? 47 : 16);
      end
    end
  endtask

  task automatic test_alt();
    do_reset();
    for (int n = 0; n < 419; n++) feed(n[0] ? 12'hFFF : 12'h000);
    for (int k = 0; k < NUM_FEAT; k++) begin
      n_chk++;
      if (ov[k] !== ((k == 0) ? 16'sd3907 : 16'sd4031)) begin
        n_fail++;
        $display("FAIL alt_f0[%0d]: got %0d expected %0d", k, ov[k], (k == 0) ? 3907 : 4031);
      end
    end
    for (int n = 419; n < 834; n++) feed(n[0] ? 12'hFFF : 12'h000);
    for (int k = 0; k < NUM_FEAT; k++) begin
      n_chk++;
      if (ov[k] !== ((k == 0) ? 16'sd3907 : 16'sd4031)) begin
        n_fail++;
        $display("FAIL alt_hold[%0d]: got %0d expected %0d", k, ov[k], (k == 0) ? 3907 : 4031);
      end
    end
    feed(12'h000);
    for (int k = 0; k < NUM_FEAT; k++) begin
      n_chk++;
      if (ov[k] !== 16'sd4031) begin
        n_fail++;
        $display("FAIL alt_f1[%0d]: got %0d expected 4031", k, ov[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (616) feed(12'hA00);
    for (int k = 0; k < NUM_FEAT; k++) begin
      n_chk++;
      if (ov[k] !== ((k == 0) ? 16'sd47 : 16'sd16)) begin
        n_fail++;
        $display("FAIL mid_before[%0d]: got %0d expected %0d", k, ov[k], (k == 0) ? 47 : 16);
      end
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < NUM_FEAT; k++) begin
      n_chk++;
      if (ov[k] !== 16'sd0) begin
        n_fail++;
        $display("FAIL mid_reset[%0d]: got %0d expected 0", k, ov[k]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (419) feed(12'hA00);
    for (int k = 0; k < NUM_FEAT; k++) begin
      n_chk++;
      if (ov[k] !== ((k == 0) ? 16'sd47 : 16'sd16)) begin
        n_fail++;
        $display("FAIL mid_after[%0d]: got %0d expected %0d", k, ov[k], (k == 0) ? 47 : 16);
      end
    end
  endtask

  task automatic test_sine();
    int xp, acc, cnt, seg, pend_at, x, y;
    logic [DATA_WIDTH-1:0] v;
    feat_vec_t msh, pend, exp_v;
    xp = 0; acc = 0; cnt = 0; seg = 0; pend_at = -1;
    msh = '{default: '0};
    pend = '{default: '0};
    exp_v = '{default: '0};
    do_reset();
    for (int n = 0; n < 4 * FRAME_LEN + 3; n++) begin
      v = 12'(2048 + $rtoi($floor(1000.0 * $sin(2.0 * 3.14159265358979 * n / 37.0) + 0.5)));
      feed(v);
      x = int'(v) - 2048;
      y = x - ((31 * xp) >>> 5);
      xp = x;
      acc += (y < 0) ? -y : y;
      if (cnt == SEG_LEN - 1) begin
        msh[seg] = feat_t'(acc >> SEG_SHIFT);
        acc = 0;
        cnt = 0;
        if (seg == NUM_FEAT - 1) begin
          pend = msh;
          pend_at = n + 3;
          seg = 0;
        end else seg++;
      end else cnt++;
      if (n == pend_at) exp_v = pend;
      for (int k = 0; k < NUM_FEAT; k++) begin
        n_chk++;
        if (ov[k] !== exp_v[k]) begin
          n_fail++;
          $display("FAIL sine[%0d] n=%0d: got %0d expected %0d", k, n, ov[k], exp_v[k]);
        end
        if (n == pend_at) begin
          n_chk++;
          if (ov[k] < 0) begin
            n_fail++;
            $display("FAIL sine_sign[%0d] n=%0d: got %0d expected >= 0", k, n, ov[k]);
          end
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_zero();
    test_const();
    test_alt();
    test_reset_mid();
    test_sine();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/top_ap.md
Name: top_ap

Overview:
Audio-processing top for the speech-recognition datapath. It takes one 12-bit offset-binary ADC sample per clock, removes the DC offset and applies pre-emphasis. It then splits each frame into 26 consecutive segments and computes the mean absolute amplitude of each segment. The resulting 26-entry signed feature vector is presented, double-buffered, to the downstream classifier.

Parameters:
DATA_WIDTH, 12, ADC sample width (offset binary).
NUM_FEAT, 26, number of features/segments per frame.
SEG_LEN, 16, samples per segment; must be a power of two.
ADC_OFFSET, 2048, mid-scale code subtracted from every sample.

Ports:
clk  input  1  system clock; one ADC sample per rising edge.
rst  input  1  reset, asynchronous, active-low; one clock domain only.
adc_data  input  DATA_WIDTH  raw ADC sample, offset binary, sampled every clk edge.
output_vector  output  signed [15:0] x NUM_FEAT (unpacked array [0:25])  feature vector of the last completed frame.

Behaviour:
- Reset (rst low, asynchronous): output_vector all 0, shadow buffer 0, x_prev 0, accumulator 0, segment and sample counters 0, pipeline valid bits 0.
- No handshake. Every rising edge with rst high captures one valid sample; the first edge after reset release is sample 0 of frame 0.
- S1 (register): x = adc_data − ADC_OFFSET, 13-bit signed, range [−2048, 2047]; valid1 <= 1.
- S2 (register, when valid1):
  - y = x − ((31·x_prev) >>> 5), with arithmetic shift (floor).
  - a = |y|; range 0..4031, held as 12-bit unsigned.
  - x_prev <= x.
  - valid2 <= valid1.
- S3 (when valid2):
  - acc += a; 16-bit unsigned, max 16·4031 = 64496, so no overflow.
  - Sample counter 0..SEG_LEN−1.
  - On the last sample of a segment: shadow[seg] <= (acc + a) >> log2(SEG_LEN), zero-extended to signed 16-bit (always positive); acc <= 0.
  - seg counter increments 0..NUM_FEAT−1.
- Frame end (seg = NUM_FEAT−1 completes):
  - On the next edge, output_vector <= shadow with the final entry included, all 26 entries atomically.
  - seg and sample counters wrap to 0; processing continues with no gap samples.
- Frame length is NUM_FEAT·SEG_LEN = 416 samples. output_vector changes exactly once per 416 samples and holds its value between updates.
- Latency: the frame-0 update is visible after the edge at which sample 415 is captured, plus 3 clk.
- x_prev is not cleared at frame boundaries; pre-emphasis is continuous across frames.
- Reset mid-frame: the partial frame is discarded, outputs return to 0, and the next frame starts at the first edge after release.

Decomposition:
- Package ap_pkg holds:
  - Constants DATA_WIDTH, NUM_FEAT, SEG_LEN, SEG_SHIFT = log2(SEG_LEN), ADC_OFFSET, FRAME_LEN.
  - typedef feat_t = logic signed [15:0].
  - typedef feat_vec_t = feat_t [NUM_FEAT].
- One natural sub-module, ap_preemph_abs: stages S1–S2 (offset removal, pre-emphasis, abs, valid).
- top_ap keeps the segment accumulator, counters, shadow buffer and output register.

Test Plan:
- Constant 0x800 for 1000 samples -> output_vector all 0 after every frame update.
- Constant 0xA00 (x = 512) for 416 samples -> entry[0] = (512 + 15·16)/16 = 47; entries[1..25] = 16.
- Alternating 0x000, 0xFFF starting with 0x000 -> entry[0] = (2048 + 15·4031)/16 = 3907; entries[1..25] = 4031.
- Update timing, with any stimulus:
  - output_vector stays 0 until 3 clk after sample 415.
  - It then changes only at sample 831 + 3, 1247 + 3, etc.
  - It is stable in between.
- Reset mid-frame: assert rst low at sample 200 of frame 1, release, then feed constant 0xA00 -> outputs 0 immediately; the first update after release equals the constant-0xA00 vector above.
- Sine input, 12-bit, amplitude 1000 → check every entry against a bit-exact reference model of the S1–S3 arithmetic over 4 frames; all entries must be ≥ 0.
